fpu_add_sched: RTL and testbench

- Shares one fixed-latency single-precision FP adder datapath (operand compare/align, add/round, normalize) between NREQ requesters.
- Arbitrates round-robin and issues one operand pair per cycle to the adder.
- Tracks each in-flight operation's requester ID through a latency-matched tag pipe.
- Buffers results in an in-order response FIFO with credit-based flow control, so no result is ever dropped.

---
 rtl/fpu_add_sched.sv | 124 ++++++++++++
 tb/tb_fpu_add_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_add_sched.sv
// Round-robin scheduler sharing one fixed-latency FP adder between NREQ requesters.
// Results return in issue order through a credit-guarded response FIFO.
module fpu_add_sched #(
   parameter int NREQ  = 2,
   parameter int LAT   = 3,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [32*NREQ-1:0]       req_a,
   input  logic [32*NREQ-1:0]       req_b,
   output logic [NREQ-1:0]          req_ready,
   output logic                     add_valid,
   output logic [31:0]              add_a,
   output logic [31:0]              add_b,
   input  logic [31:0]              add_res,
   output logic                     rsp_valid,
   output logic [31:0]              rsp_data,
   output logic [$clog2(NREQ)-1:0]  rsp_id,
   input  logic                     rsp_ready
);
   localparam int IDW = $clog2(NREQ);
   localparam int CW  = $clog2(DEPTH + 1);
   localparam int AW  = $clog2(DEPTH);

   logic [NREQ-1:0][31:0] a_v, b_v;
   assign a_v = req_a;
   assign b_v = req_b;

   logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
   logic [LAT:0]            vld_pipe_q, vld_pipe_d;
   logic [LAT:0][IDW-1:0]   id_pipe_q, id_pipe_d;
   logic [31:0]             add_a_q, add_a_d, add_b_q, add_b_d;
   logic [CW-1:0]           in_flight_q, in_flight_d;
   logic [CW-1:0]           fifo_cnt_q, fifo_cnt_d;
   logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [31:0]             mem_data_q [DEPTH];
   logic [IDW-1:0]          mem_id_q   [DEPTH];

   logic           can_issue, gnt_vld, push, pop;
   logic [IDW-1:0] gnt_id;
   logic [IDW:0]   scan, rr_nx;
   logic [CW:0]    occ;

   // Credits cover both ops in the adder and results parked in the FIFO.
   always_comb begin
      occ       = {1'b0, in_flight_q} + {1'b0, fifo_cnt_q};
      can_issue = occ < (CW+1)'(DEPTH);
      gnt_vld   = 1'b0;
      gnt_id    = '0;
      scan      = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan = {1'b0, rr_ptr_q} + (IDW+1)'(k);
         if (scan >= (IDW+1)'(NREQ)) scan = scan - (IDW+1)'(NREQ);
         if (can_issue && !gnt_vld && req_valid[scan[IDW-1:0]]) begin
            gnt_vld = 1'b1;
            gnt_id  = scan[IDW-1:0];
         end
      end
      req_ready = gnt_vld ? (NREQ'(1) << gnt_id) : '0;
   end

   assign push      = vld_pipe_q[LAT];
   assign rsp_valid = fifo_cnt_q != '0;
   assign pop       = rsp_valid && rsp_ready;

   always_comb begin
      rr_nx    = {1'b0, gnt_id} + (IDW+1)'(1);
      rr_ptr_d = rr_ptr_q;
      if (gnt_vld) rr_ptr_d = (rr_nx == (IDW+1)'(NREQ)) ? '0 : rr_nx[IDW-1:0];
      vld_pipe_d  = {vld_pipe_q[LAT-1:0], gnt_vld};
      id_pipe_d   = {id_pipe_q[LAT-1:0], gnt_id};
      add_a_d     = gnt_vld ? a_v[gnt_id] : add_a_q;
      add_b_d     = gnt_vld ? b_v[gnt_id] : add_b_q;
      in_flight_d = in_flight_q + CW'(gnt_vld) - CW'(push);
      fifo_cnt_d  = fifo_cnt_q + CW'(push) - CW'(pop);
      wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d    = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q    <= '0;
         vld_pipe_q  <= '0;
         id_pipe_q   <= '0;
         add_a_q     <= '0;
         add_b_q     <= '0;
         in_flight_q <= '0;
         fifo_cnt_q  <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         vld_pipe_q  <= vld_pipe_d;
         id_pipe_q   <= id_pipe_d;
         add_a_q     <= add_a_d;
         add_b_q     <= add_b_d;
         in_flight_q <= in_flight_d;
         fifo_cnt_q  <= fifo_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_data_q[wr_ptr_q] <= add_res;
         mem_id_q[wr_ptr_q]   <= id_pipe_q[LAT];
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (rst_n) assert (!(push && fifo_cnt_q == CW'(DEPTH)));
   end
`endif

   assign add_valid = vld_pipe_q[0];
   assign add_a     = add_a_q;
   assign add_b     = add_b_q;
   assign rsp_data  = rsp_valid ? mem_data_q[rd_ptr_q] : '0;
   assign rsp_id    = rsp_valid ? mem_id_q[rd_ptr_q] : '0;
endmodule

// File: tb/tb_fpu_add_sched.sv
// Bench for fpu_add_sched: model adder, queue-based reference of credits,
// round-robin order and in-order responses, plus directed corner sequences.
module tb_fpu_add_sched;
   localparam int NREQ = 2, LAT = 3, DEPTH = 4;

   logic clk = 1'b0, rst_n = 1'b0;
   logic [NREQ-1:0] req_valid, req_ready;
   logic [32*NREQ-1:0] req_a, req_b;
   logic add_valid, rsp_valid, rsp_ready;
   logic [31:0] add_a, add_b, add_res, rsp_data;
   logic [$clog2(NREQ)-1:0] rsp_id;

   always #5 clk = ~clk;

   fpu_add_sched #(.NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .add_valid(add_valid), .add_a(add_a), .add_b(add_b),
      .add_res(add_res), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
      .rsp_ready(rsp_ready));

   function automatic real s2r(logic [31:0] f);
      real m;
      if (f[30:23] == 8'd0) return 0.0;
      m = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** (real'(f[30:23]) - 127.0));
      return f[31] ? -m : m;
   endfunction

   function automatic logic [31:0] fadd(logic [31:0] a, logic [31:0] b);
      logic [63:0] d;
      logic [10:0] de;
      d  = $realtobits(s2r(a) + s2r(b));
      de = d[62:52];
      if (de == 11'd0) return {d[63], 31'd0};
      return {d[63], 8'(de - 11'd896), d[51:29]};
   endfunction

   function automatic logic [31:0] rnd_op();
      logic [31:0] r;
      r = $urandom;
      r[30:23] = 8'(110 + $urandom_range(0, 30));
      return r;
   endfunction

   // Model adder: result of the operands presented in cycle c appears in cycle c+LAT.
   logic [31:0] apipe [LAT];
   always @(posedge clk) begin
      apipe[0] <= fadd(add_a, add_b);
      for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
   end
   assign add_res = apipe[LAT-1];

   int n_chk = 0, n_fail = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: outstanding ops = accepted minus popped; each response due LAT+2 cycles after accept.
   typedef struct { int id; logic [31:0] data; int due; } rsp_t;
   rsp_t sb[$];
   int cyc = 0, occ = 0, mrr = 0, eg;
   logic ev, p_acc = 1'b0;
   logic [31:0] p_a = '0, p_b = '0;

   initial forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
         sb.delete(); occ = 0; mrr = 0; p_acc = 1'b0; p_a = '0; p_b = '0;
      end else begin
         eg = -1;
         if (occ < DEPTH)
            for (int k = 0; k < NREQ; k++)
               if (eg < 0 && req_valid[(mrr + k) % NREQ]) eg = (mrr + k) % NREQ;
         chk("m_req_ready", 32'(req_ready), eg >= 0 ? 32'(1 << eg) : 32'd0);
         chk("m_add_valid", 32'(add_valid), 32'(p_acc));
         chk("m_add_a", add_a, p_a);
         chk("m_add_b", add_b, p_b);
         ev = sb.size() > 0 && sb[0].due <= cyc;
         chk("m_rsp_valid", 32'(rsp_valid), 32'(ev));
         if (ev) begin
            chk("m_rsp_data", rsp_data, sb[0].data);
            chk("m_rsp_id", 32'(rsp_id), 32'(sb[0].id));
            if (rsp_ready) begin void'(sb.pop_front()); occ--; end
         end
         p_acc = eg >= 0;
         if (eg >= 0) begin
            p_a = req_a[32*eg +: 32];
            p_b = req_b[32*eg +: 32];
            sb.push_back('{eg, fadd(p_a, p_b), cyc + LAT + 2});
            occ++;
            mrr = (eg + 1) % NREQ;
         end
      end
   end

   typedef struct { logic [1:0] rv; logic [31:0] a, b; logic [1:0] rdy; logic [31:0] res; } vec_t;
   vec_t vt [8];

   task automatic bp_check(input string tag);
      int n;
      logic [31:0] head;
      rsp_ready = 1'b0; req_valid = '1; n = 0;
      for (int c = 0; c < 12; c++) begin
         req_a = {rnd_op(), rnd_op()}; req_b = {rnd_op(), rnd_op()};
         @(negedge clk); #1;
         if (req_ready != '0) n++;
         @(posedge clk); #1;
      end
      chk({tag, "_accepts"}, n, 4);
      @(negedge clk); #1;
      chk({tag, "_blocked"}, 32'(req_ready), 32'd0);
      chk({tag, "_full_valid"}, 32'(rsp_valid), 32'd1);
      head = rsp_data;
      repeat (3) @(negedge clk);
      #1 chk({tag, "_stall_hold"}, rsp_data, head);
      @(posedge clk); #1; rsp_ready = 1'b1;
      @(negedge clk); #1;
      chk({tag, "_pop_cycle"}, 32'(req_ready), 32'd0);
      @(posedge clk); #1; rsp_ready = 1'b0;
      @(negedge clk); #1;
      chk({tag, "_one_grant"}, $countones(req_ready), 1);
      n = 0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1; @(negedge clk); #1;
         if (req_ready != '0) n++;
      end
      chk({tag, "_no_extra"}, n, 0);
      @(posedge clk); #1; req_valid = '0; rsp_ready = 1'b1;
      repeat (15) @(posedge clk); #1;
   endtask

   initial begin
      int ng, nr, lid, seen;
      logic [1:0] lg, lgn;
      vt[0] = '{2'b01, 32'h3F800000, 32'h40000000, 2'b01, 32'h40400000};
      vt[1] = '{2'b10, 32'h40000000, 32'h40000000, 2'b10, 32'h40800000};
      vt[2] = '{2'b01, 32'h3F800000, 32'h3F800000, 2'b01, 32'h40000000};
      vt[3] = '{2'b11, 32'h3FC00000, 32'h3F000000, 2'b10, 32'h40000000};
      vt[4] = '{2'b11, 32'h40400000, 32'h3F800000, 2'b01, 32'h40800000};
      vt[5] = '{2'b00, 32'h00000000, 32'h00000000, 2'b00, 32'h00000000};
      vt[6] = '{2'b01, 32'h40A00000, 32'h40400000, 2'b01, 32'h41000000};
      vt[7] = '{2'b11, 32'h3F000000, 32'h3E800000, 2'b10, 32'h3F400000};
      req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
      repeat (3) @(posedge clk); #1;
      chk("rst_add_valid", 32'(add_valid), 32'd0);
      chk("rst_add_a", add_a, 32'd0);
      chk("rst_add_b", add_b, 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      rst_n = 1'b1;

      for (int r = 0; r < 8; r++) begin
         req_valid = vt[r].rv; req_a = {NREQ{vt[r].a}}; req_b = {NREQ{vt[r].b}};
         @(negedge clk); #1;
         chk("vec_ready", 32'(req_ready), 32'(vt[r].rdy));
         @(posedge clk); #1; req_valid = '0;
         if (vt[r].rdy != 2'b00) begin
            @(negedge clk); #1;
            chk("vec_add_valid", 32'(add_valid), 32'd1);
            chk("vec_add_a", add_a, vt[r].a);
            chk("vec_add_b", add_b, vt[r].b);
            repeat (3) @(negedge clk);
            #1 chk("vec_no_bypass", 32'(rsp_valid), 32'd0);
            @(negedge clk); #1;
            chk("vec_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("vec_rsp_data", rsp_data, vt[r].res);
            chk("vec_rsp_id", 32'(rsp_id), vt[r].rdy == 2'b10 ? 32'd1 : 32'd0);
         end
         repeat (2) @(posedge clk); #1;
      end

      bp_check("bp");

      req_valid = '1; rsp_ready = 1'b1; ng = 0; nr = 0; lg = '0; lid = 0;
      for (int c = 0; c < 600 && ng < 100; c++) begin
         req_a = {rnd_op(), rnd_op()}; req_b = {rnd_op(), rnd_op()};
         @(negedge clk); #1;
         if (req_ready != '0) begin
            lgn = ~lg;
            if (ng > 0) chk("stream_alt", 32'(req_ready), 32'(lgn));
            lg = req_ready; ng++;
         end
         if (rsp_valid && rsp_ready) begin
            if (nr > 0) chk("stream_id", 32'(rsp_id), 32'(1 - lid));
            lid = int'(rsp_id); nr++;
         end
         @(posedge clk); #1;
      end
      chk("stream_count", ng, 100);
      req_valid = '0;
      repeat (15) @(posedge clk); #1;
      bp_check("post_stream");

      for (int c = 0; c < 1500; c++) begin
         req_valid = NREQ'($urandom); rsp_ready = ($urandom_range(0, 3) != 0);
         req_a = {rnd_op(), rnd_op()}; req_b = {rnd_op(), rnd_op()};
         @(posedge clk); #1;
      end
      req_valid = '0; rsp_ready = 1'b1;
      repeat (20) @(posedge clk); #1;
      chk("drain_empty", sb.size(), 0);

      rsp_ready = 1'b0; req_valid = 2'b01;
      req_a = {NREQ{32'h3F800000}}; req_b = {NREQ{32'h40000000}};
      @(posedge clk); #1; req_valid = '0;
      repeat (6) @(posedge clk); #1;
      chk("pre_rst_buffered", 32'(rsp_valid), 32'd1);
      req_valid = 2'b10; @(posedge clk); #1;
      req_valid = 2'b01; @(posedge clk); #1;
      req_valid = '0;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_add_valid", 32'(add_valid), 32'd0);
      chk("mid_rst_add_a", add_a, 32'd0);
      chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("mid_rst_rsp_data", rsp_data, 32'd0);
      chk("mid_rst_rsp_id", 32'(rsp_id), 32'd0);
      @(posedge clk); #1; rst_n = 1'b1; rsp_ready = 1'b1;
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk); #1;
         if (rsp_valid) seen++;
      end
      chk("stale_ignored", seen, 0);
      @(posedge clk); #1; req_valid = 2'b01;
      @(negedge clk); #1;
      chk("post_rst_grant", 32'(req_ready), 32'd1);
      @(posedge clk); #1; req_valid = '0;
      seen = 0;
      for (int c = 0; c < 20 && seen == 0; c++) begin
         @(negedge clk); #1;
         if (rsp_valid) seen = c + 1;
      end
      chk("post_rst_latency", seen, LAT + 2);
      chk("post_rst_data", rsp_data, 32'h40400000);
      chk("post_rst_id", 32'(rsp_id), 32'd0);
      repeat (5) @(posedge clk); #1;
      chk("final_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
      $fatal(1, "watchdog expired");
   end
endmodule
